jpeg_idct_buf_param: RTL and testbench

//  Parametrised multi-block coefficient buffer between the run-length/dequant stage and the IDCT.

---
 rtl/jpeg_pkg.sv | 24 ++
 rtl/jpeg_idct_bank_ram.sv | 27 ++
 rtl/jpeg_idct_buf_param.sv | 206 ++++++++++++++++++++
 tb/tb_jpeg_idct_buf_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG IDCT coefficient buffer.
// Index split, read FSM state encoding and the bank skew used on both ports.
package jpeg_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_ACTIVE = 2'd2
    } rd_state_e;

    function automatic logic [2:0] idx_row(input logic [5:0] idx);
        return idx[5:3];
    endfunction

    function automatic logic [2:0] idx_col(input logic [5:0] idx);
        return idx[2:0];
    endfunction

    // Diagonal skew: any LANES-aligned run along a row or a column hits distinct banks.
    function automatic int bank_skew(input int row, input int col, input int lanes);
        return (row + col) % lanes;
    endfunction

endpackage

// File: rtl/jpeg_idct_bank_ram.sv
// One coefficient bank: simple 1W1R synchronous RAM with a held read register.
// The read register only updates on re_i, so a stalled output beat stays put.
module jpeg_idct_bank_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[waddr_i] <= wdata_i;
        if (re_i) r_rdata <= r_mem[raddr_i];
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/jpeg_idct_buf_param.sv
// Multi-block 8x8 coefficient buffer feeding the IDCT: sparse writes, zero fill,
// row-order or transposed LANES-wide drain with valid/ready on both sides.
module jpeg_idct_buf_param
    import jpeg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_BLOCKS = 4,
    parameter int LANES      = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           img_start_i,
    input  logic                           inport_valid_i,
    input  logic [DATA_W-1:0]              inport_data_i,
    input  logic [5:0]                     inport_idx_i,
    input  logic                           inport_eob_i,
    input  logic                           inport_transpose_i,
    output logic                           inport_accept_o,
    output logic                           outport_valid_o,
    input  logic                           outport_ready_i,
    output logic [LANES*DATA_W-1:0]        outport_data_o,
    output logic [2:0]                     outport_line_o,
    output logic [2:0]                     outport_pos_o,
    output logic                           outport_last_o,
    output logic                           outport_transpose_o,
    output logic [$clog2(NUM_BLOCKS):0]    level_o,
    output logic [1:0]                     dbg_state_o
);

    localparam int BLK_W  = $clog2(NUM_BLOCKS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int NBEATS = 64 / LANES;
    localparam int BPL    = 8 / LANES;
    localparam int BEAT_W = 6 - LANE_W;
    localparam int DEPTH  = NUM_BLOCKS * NBEATS;
    localparam int AW     = BLK_W + BEAT_W;

    // Handshake: a beat moves on a clock edge where outport_valid_o && outport_ready_i;
    // a coefficient/eob moves where inport_accept_o is high; valid never waits on ready.

    rd_state_e                      r_state;
    logic [BLK_W-1:0]               r_wr_blk, r_rd_blk, w_rd_next;
    logic [NUM_BLOCKS-1:0]          r_ready, r_tp;
    logic [NUM_BLOCKS-1:0][63:0]    r_vmap;
    logic [BLK_W:0]                 r_level;
    logic [BEAT_W-1:0]              r_beat;
    logic                           r_valid, r_last, r_tpo;
    logic [2:0]                     r_line, r_pos;
    logic [LANES-1:0]               r_mask, w_mask, w_we;
    logic                           w_accept, w_wr_fire, w_eob_fire, w_issue, w_last_acc, w_tp;
    logic [2:0]                     w_row, w_col, w_iline, w_ipos;
    logic [AW-1:0]                  w_waddr;
    logic [AW-1:0]                  w_raddr [LANES];
    logic [DATA_W-1:0]              w_rdata [LANES];

    function automatic logic [AW-1:0] rd_addr(input int blk, input int line, input int pos,
                                              input int lane, input logic tp);
        int a;
        if (tp) a = blk * NBEATS + (pos + lane) * BPL + line / LANES;
        else    a = blk * NBEATS + line * BPL + pos / LANES;
        return AW'(a);
    endfunction

    function automatic logic [5:0] lane_idx(input int line, input int pos, input int lane,
                                            input logic tp);
        if (tp) return 6'((pos + lane) * 8 + line);
        else    return 6'(line * 8 + pos + lane);
    endfunction

    assign w_row      = idx_row(inport_idx_i);
    assign w_col      = idx_col(inport_idx_i);
    assign w_accept   = !r_ready[r_wr_blk];
    assign w_wr_fire  = inport_valid_i && w_accept;
    assign w_eob_fire = inport_eob_i && w_accept;
    assign w_waddr    = AW'(int'(r_wr_blk) * NBEATS + int'(w_row) * BPL + int'(w_col) / LANES);
    assign w_tp       = r_tp[r_rd_blk];
    assign w_rd_next  = r_rd_blk + 1'b1;
    assign w_iline    = 3'(int'(r_beat) / BPL);
    assign w_ipos     = 3'((int'(r_beat) % BPL) * LANES);
    assign w_issue    = (r_state == RD_FETCH) ||
                        (r_state == RD_ACTIVE && r_valid && outport_ready_i && !r_last);
    assign w_last_acc = (r_state == RD_ACTIVE) && r_valid && outport_ready_i && r_last;

    // Logical lane j of any beat lives in bank (j + line) mod LANES.
    always_comb begin
        w_we   = '0;
        w_mask = '0;
        for (int b = 0; b < LANES; b++) begin
            w_we[b]    = w_wr_fire && (bank_skew(int'(w_row), int'(w_col), LANES) == b);
            w_raddr[b] = rd_addr(int'(r_rd_blk), int'(w_iline), int'(w_ipos),
                                 (b + LANES - int'(w_iline) % LANES) % LANES, w_tp);
            w_mask[b]  = r_vmap[r_rd_blk][lane_idx(int'(w_iline), int'(w_ipos), b, w_tp)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        jpeg_idct_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
            .clk_i   (clk_i),
            .we_i    (w_we[g]),
            .waddr_i (w_waddr),
            .wdata_i (inport_data_i),
            .re_i    (w_issue),
            .raddr_i (w_raddr[g]),
            .rdata_o (w_rdata[g])
        );
    end

    always_comb begin
        outport_data_o = '0;
        for (int j = 0; j < LANES; j++) begin
            if (r_mask[j]) outport_data_o[j*DATA_W +: DATA_W] = w_rdata[(j + int'(r_line)) % LANES];
        end
    end

    // Write side, slot ownership and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_blk <= '0;
            r_ready  <= '0;
            r_tp     <= '0;
            r_vmap   <= '0;
            r_level  <= '0;
        end else if (img_start_i) begin
            r_wr_blk <= '0;
            r_ready  <= '0;
            r_tp     <= '0;
            r_vmap   <= '0;
            r_level  <= '0;
        end else begin
            if (w_last_acc) begin
                r_ready[r_rd_blk] <= 1'b0;
                r_vmap[r_rd_blk]  <= '0;
            end
            if (w_wr_fire) r_vmap[r_wr_blk][inport_idx_i] <= 1'b1;
            if (w_eob_fire) begin
                r_ready[r_wr_blk] <= 1'b1;
                r_tp[r_wr_blk]    <= inport_transpose_i;
                r_wr_blk          <= r_wr_blk + 1'b1;
            end
            case ({w_eob_fire, w_last_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Read FSM; going straight to FETCH after a last beat keeps the gap to one bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= RD_IDLE;
            r_rd_blk <= '0;
            r_beat   <= '0;
            r_valid  <= 1'b0;
            r_line   <= '0;
            r_pos    <= '0;
            r_last   <= 1'b0;
            r_tpo    <= 1'b0;
            r_mask   <= '0;
        end else if (img_start_i) begin
            r_state  <= RD_IDLE;
            r_rd_blk <= '0;
            r_beat   <= '0;
            r_valid  <= 1'b0;
            r_line   <= '0;
            r_pos    <= '0;
            r_last   <= 1'b0;
            r_tpo    <= 1'b0;
            r_mask   <= '0;
        end else begin
            case (r_state)
                RD_IDLE:   if (r_ready[r_rd_blk]) r_state <= RD_FETCH;
                RD_FETCH:  r_state <= RD_ACTIVE;
                RD_ACTIVE: begin
                    if (w_last_acc) begin
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                        r_rd_blk <= w_rd_next;
                        r_beat   <= '0;
                        r_state  <= r_ready[w_rd_next] ? RD_FETCH : RD_IDLE;
                    end
                end
                default:   r_state <= RD_IDLE;
            endcase
            if (w_issue) begin
                r_valid <= 1'b1;
                r_line  <= w_iline;
                r_pos   <= w_ipos;
                r_last  <= (r_beat == BEAT_W'(NBEATS - 1));
                r_tpo   <= w_tp;
                r_mask  <= w_mask;
                r_beat  <= r_beat + 1'b1;
            end
        end
    end

    assign inport_accept_o     = w_accept;
    assign outport_valid_o     = r_valid;
    assign outport_line_o      = r_line;
    assign outport_pos_o       = r_pos;
    assign outport_last_o      = r_last;
    assign outport_transpose_o = r_tpo;
    assign level_o             = r_level;
    assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_jpeg_idct_buf_param.sv
// Directed bench for jpeg_idct_buf_param (DATA_W=16, NUM_BLOCKS=4, LANES=4):
// vector table for key beats, reference-model scoreboard for every drained beat.
module tb_jpeg_idct_buf_param;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        img_start_i = 1'b0;
    logic        inport_valid_i = 1'b0;
    logic [15:0] inport_data_i = '0;
    logic [5:0]  inport_idx_i = '0;
    logic        inport_eob_i = 1'b0;
    logic        inport_transpose_i = 1'b0;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic        outport_ready_i = 1'b0;
    logic [63:0] outport_data_o;
    logic [2:0]  outport_line_o;
    logic [2:0]  outport_pos_o;
    logic        outport_last_o;
    logic        outport_transpose_o;
    logic [2:0]  level_o;
    logic [1:0]  dbg_state_o;

    jpeg_idct_buf_param #(.DATA_W(16), .NUM_BLOCKS(4), .LANES(4)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .img_start_i         (img_start_i),
        .inport_valid_i      (inport_valid_i),
        .inport_data_i       (inport_data_i),
        .inport_idx_i        (inport_idx_i),
        .inport_eob_i        (inport_eob_i),
        .inport_transpose_i  (inport_transpose_i),
        .inport_accept_o     (inport_accept_o),
        .outport_valid_o     (outport_valid_o),
        .outport_ready_i     (outport_ready_i),
        .outport_data_o      (outport_data_o),
        .outport_line_o      (outport_line_o),
        .outport_pos_o       (outport_pos_o),
        .outport_last_o      (outport_last_o),
        .outport_transpose_o (outport_transpose_o),
        .level_o             (level_o),
        .dbg_state_o         (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [71:0] exp_q[$];
    logic [15:0] mdl [64];
    logic [71:0] cap [64];

    typedef struct {
        int          tid;
        int          beat;
        logic [63:0] data;
        logic [2:0]  line;
        logic [2:0]  pos;
        logic        last;
        logic        tp;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mdl[i] = '0;
    endtask

    // Reference beat order: normal rows, transposed columns, 4 lanes ascending.
    task automatic push_block(input logic tp);
        logic [63:0] d;
        int idx;
        for (int b = 0; b < 16; b++) begin
            int line = b / 2;
            int pos  = (b % 2) * 4;
            d = '0;
            for (int k = 0; k < 4; k++) begin
                idx = tp ? (pos + k) * 8 + line : line * 8 + pos + k;
                d[k*16 +: 16] = mdl[idx];
            end
            exp_q.push_back({d, 3'(line), 3'(pos), (b == 15), tp});
        end
    endtask

    // driver: one coefficient / eob, waits (bounded) for accept
    task automatic put(input int idx, input logic [15:0] val, input logic vld,
                       input logic eob, input logic tp);
        int n = 0;
        inport_valid_i     = vld;
        inport_data_i      = val;
        inport_idx_i       = 6'(idx);
        inport_eob_i       = eob;
        inport_transpose_i = tp;
        while (!inport_accept_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: idx %0d never accepted", idx);
        end
        if (vld) mdl[idx] = val;
        tick();
        if (eob) begin
            push_block(tp);
            clear_model();
        end
        inport_valid_i     = 1'b0;
        inport_eob_i       = 1'b0;
        inport_transpose_i = 1'b0;
    endtask

    // scoreboard drain: accepts nbeats beats, checks stall stability, ends one edge after the last accept
    task automatic drain(input int nbeats, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [71:0] prev = '0;
        logic [71:0] cur;
        while (got < nbeats && cyc < 2000) begin
            tick();
            cyc++;
            cur = {outport_data_o, outport_line_o, outport_pos_o, outport_last_o, outport_transpose_o};
            if (stalled) check("stall_hold", {outport_valid_o, cur}, {1'b1, prev});
            outport_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (outport_valid_o && outport_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h expected none", cur);
                end else begin
                    check("beat", cur, exp_q.pop_front());
                end
                cap[got] = cur;
                got++;
                stalled = 0;
            end else begin
                stalled = outport_valid_o;
                prev = cur;
            end
        end
        if (got < nbeats) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats expected %0d", got, nbeats);
        end
        tick();
        outport_ready_i = 1'b0;
    endtask

    task automatic check_table(input int tid);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].tid == tid)
                check($sformatf("t%0d_beat%0d", tid, tbl[i].beat), cap[tbl[i].beat],
                      {tbl[i].data, tbl[i].line, tbl[i].pos, tbl[i].last, tbl[i].tp});
        end
    endtask

    initial begin
        tbl[0] = '{1, 0,  {16'd3,  16'd2,  16'd1,  16'd0},  3'd0, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1, 1,  {16'd7,  16'd6,  16'd5,  16'd4},  3'd0, 3'd4, 1'b0, 1'b0};
        tbl[2] = '{1, 15, {16'd63, 16'd62, 16'd61, 16'd60}, 3'd7, 3'd4, 1'b1, 1'b0};
        tbl[3] = '{2, 0,  {16'd24, 16'd16, 16'd8,  16'd0},  3'd0, 3'd0, 1'b0, 1'b1};
        tbl[4] = '{2, 1,  {16'd56, 16'd48, 16'd40, 16'd32}, 3'd0, 3'd4, 1'b0, 1'b1};
        tbl[5] = '{2, 15, {16'd63, 16'd55, 16'd47, 16'd39}, 3'd7, 3'd4, 1'b1, 1'b1};
        tbl[6] = '{3, 0,  {16'd0,  16'd0,  16'd0,  16'd5},  3'd0, 3'd0, 1'b0, 1'b0};
        tbl[7] = '{3, 15, {16'hFFFF, 16'd0, 16'd0, 16'd0},  3'd7, 3'd4, 1'b1, 1'b0};
        clear_model();

        // reset state
        repeat (3) tick();
        check("rst_valid", outport_valid_o, 1'b0);
        check("rst_accept", inport_accept_o, 1'b1);
        check("rst_level", level_o, 3'd0);
        check("rst_side", {outport_data_o, outport_line_o, outport_pos_o, outport_last_o,
                           outport_transpose_o, dbg_state_o}, '0);
        rst_ni = 1'b1;
        tick();

        // 1: full block, row order, plus eob latency
        for (int i = 0; i < 64; i++) put(i, 16'(i), 1'b1, (i == 63), 1'b0);
        check("lat_c0", outport_valid_o, 1'b0);
        check("lat_level", level_o, 3'd1);
        tick();
        check("lat_c1", outport_valid_o, 1'b0);
        tick();
        check("lat_c2", outport_valid_o, 1'b1);
        drain(16, 1'b0);
        check_table(1);

        // 2: same block, transposed
        for (int i = 0; i < 64; i++) put(i, 16'(i), 1'b1, (i == 63), 1'b1);
        drain(16, 1'b0);
        check_table(2);

        // 3: sparse block, zero fill, eob without data
        put(0, 16'd5, 1'b1, 1'b0, 1'b0);
        put(63, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        put(0, 16'd0, 1'b0, 1'b1, 1'b0);
        drain(16, 1'b0);
        check_table(3);

        // 4: fill all slots with the sink stalled
        for (int b = 0; b < 4; b++) begin
            put(b * 9, 16'(100 + b), 1'b1, 1'b0, 1'b0);
            put(b * 9, 16'(300 + b), 1'b1, 1'b0, 1'b0);
            put(b * 9 + 1, 16'(200 + b), 1'b1, 1'b1, 1'(b % 2));
        end
        check("full_level", level_o, 3'd4);
        check("full_accept", inport_accept_o, 1'b0);
        repeat (3) tick();
        check("full_hold", {inport_accept_o, outport_valid_o, dbg_state_o}, {1'b0, 1'b1, 2'd2});
        drain(16, 1'b0);
        check("free_accept", inport_accept_o, 1'b1);
        check("free_level", level_o, 3'd3);
        check("bubble", outport_valid_o, 1'b0);
        tick();
        check("bubble_end", outport_valid_o, 1'b1);
        drain(48, 1'b0);
        check("empty_level", level_o, 3'd0);

        // 5: random backpressure
        for (int i = 0; i < 64; i++) put(i, 16'(i * 3 + 100), 1'b1, (i == 63), 1'b1);
        drain(16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_extra", {outport_valid_o, 7'(exp_q.size())}, '0);
        end

        // 6a: img_start mid-drain
        for (int i = 0; i < 64; i++) put(i, 16'hA000 + 16'(i), 1'b1, (i == 63), 1'b0);
        drain(5, 1'b0);
        img_start_i = 1'b1;
        tick();
        img_start_i = 1'b0;
        check("clr_valid", outport_valid_o, 1'b0);
        check("clr_level", level_o, 3'd0);
        check("clr_accept", inport_accept_o, 1'b1);
        exp_q.delete();
        put(10, 16'h1234, 1'b1, 1'b1, 1'b0);
        drain(16, 1'b0);

        // 6b: async reset mid-write
        put(5, 16'h0055, 1'b1, 1'b1, 1'b0);
        put(1, 16'd11, 1'b1, 1'b0, 1'b0);
        put(2, 16'd22, 1'b1, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", outport_valid_o, 1'b0);
        check("arst_level", level_o, 3'd0);
        check("arst_accept", inport_accept_o, 1'b1);
        tick();
        rst_ni = 1'b1;
        exp_q.delete();
        clear_model();
        tick();
        put(63, 16'd7, 1'b1, 1'b1, 1'b0);
        drain(16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
